opl3_reg_wr_arbiter: RTL and testbench

- Shares the single OPL3 register-file write port between two requesters.
  - Host path: decoded host writes coming out of the host clock-domain FIFO.
  - Sequencer path: an internal register sequencer, such as a patch loader or init/mute sequencer.
- Buffers host writes, because the host side cannot be back-pressured.
- Arbitrates round-robin and enforces a minimum spacing between issued writes, so the register file and operator pipeline see paced updates.
- Sits in the clk domain, between the host interface / sequencer and the register file.

---
 rtl/opl3_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/opl3_reg_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_opl3_reg_wr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared register-file types for the OPL3 core: write payload, arbiter state
// and requester identity.
package opl3_pkg;

  localparam int REG_FILE_ADDR_WIDTH = 9;
  localparam int REG_FILE_DATA_WIDTH = 8;

  typedef struct packed {
    logic [REG_FILE_ADDR_WIDTH-1:0] addr;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } reg_wr_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_t;

  typedef enum logic {
    HOST = 1'b0,
    SEQ  = 1'b1
  } requester_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/level status. A pop frees its slot in the
// same cycle, so a push into a full FIFO is accepted when a pop coincides.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/opl3_reg_wr_arbiter.sv
// Shares the OPL3 register-file write port between buffered host writes and the
// internal sequencer, round-robin with paced issue. Define OPL3_REG_WR_ARB_STATS_EN
// to add issued-write counters and a host FIFO high-water mark.
module opl3_reg_wr_arbiter
  import opl3_pkg::*;
#(
  parameter int HOST_DEPTH = 8,
  parameter int MIN_GAP    = 4,
  localparam int LW = $clog2(HOST_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           host_wr_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [REG_FILE_DATA_WIDTH-1:0] host_wr_data,
  output logic                           host_wr_full,
  input  logic                           seq_wr_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] seq_wr_addr,
  input  logic [REG_FILE_DATA_WIDTH-1:0] seq_wr_data,
  output logic                           seq_wr_ready,
  output logic                           opl3_reg_wr_valid,
  output logic [REG_FILE_ADDR_WIDTH-1:0] opl3_reg_wr_addr,
  output logic [REG_FILE_DATA_WIDTH-1:0] opl3_reg_wr_data,
  output logic                           host_overflow,
  output logic                           busy,
  output arb_state_t                     arb_state
`ifdef OPL3_REG_WR_ARB_STATS_EN
  ,
  output logic [15:0]                    host_wr_count,
  output logic [15:0]                    seq_wr_count,
  output logic [LW-1:0]                  max_fifo_level
`endif
);

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);

  reg_wr_t    host_in;
  reg_wr_t    host_head;
  reg_wr_t    seq_in;
  reg_wr_t    grant_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [LW-1:0] fifo_level;
  arb_state_t state_q, state_d;
  logic [7:0] gap_q, gap_d;
  requester_t last_q;
  requester_t grant_who;
  logic       grant;
  logic       req_h;
  logic       req_s;

  assign host_in.addr = host_wr_addr;
  assign host_in.data = host_wr_data;
  assign seq_in.addr  = seq_wr_addr;
  assign seq_in.data  = seq_wr_data;

  sync_fifo #(
    .WIDTH($bits(reg_wr_t)),
    .DEPTH(HOST_DEPTH)
  ) u_host_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (host_wr_valid),
    .wdata  (host_in),
    .pop    (fifo_pop),
    .rdata  (host_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign req_h = !fifo_empty;
  assign req_s = seq_wr_valid;

  // Sequencer handshake: seq_wr_valid is held with stable addr/data until a
  // cycle where seq_wr_ready is high; the write transfers at that clock edge.
  // seq_wr_ready depends combinationally on seq_wr_valid and is only high in IDLE.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    grant     = 1'b0;
    grant_who = HOST;
    case (state_q)
      IDLE: begin
        if (req_h || req_s) begin
          grant = 1'b1;
          if (req_h && req_s) grant_who = (last_q == SEQ) ? HOST : SEQ;
          else                grant_who = req_h ? HOST : SEQ;
          gap_d = GAP_LOAD;
          if (GAP_LOAD != 8'd0) state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gap_d   = 8'd0;
      end
    endcase
  end

  assign fifo_pop     = grant && (grant_who == HOST);
  assign seq_wr_ready = grant && (grant_who == SEQ);
  assign grant_wr     = (grant_who == SEQ) ? seq_in : host_head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      gap_q             <= 8'd0;
      last_q            <= SEQ;
      opl3_reg_wr_valid <= 1'b0;
      opl3_reg_wr_addr  <= '0;
      opl3_reg_wr_data  <= '0;
      host_overflow     <= 1'b0;
    end else begin
      state_q           <= state_d;
      gap_q             <= gap_d;
      opl3_reg_wr_valid <= grant;
      if (grant) begin
        opl3_reg_wr_addr <= grant_wr.addr;
        opl3_reg_wr_data <= grant_wr.data;
        last_q           <= grant_who;
      end
      // A full FIFO still takes the write when the head leaves this cycle.
      if (host_wr_valid && fifo_full && !fifo_pop) host_overflow <= 1'b1;
    end
  end

  assign host_wr_full = fifo_full;
  assign busy         = (fifo_level != '0) || seq_wr_valid || (gap_q != 8'd0);
  assign arb_state    = state_q;

`ifdef OPL3_REG_WR_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_wr_count  <= 16'd0;
      seq_wr_count   <= 16'd0;
      max_fifo_level <= '0;
    end else begin
      if (fifo_pop && host_wr_count != 16'hFFFF)    host_wr_count <= host_wr_count + 16'd1;
      if (seq_wr_ready && seq_wr_count != 16'hFFFF) seq_wr_count  <= seq_wr_count + 16'd1;
      if (fifo_level > max_fifo_level)              max_fifo_level <= fifo_level;
    end
  end
`endif

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// Directed bench for opl3_reg_wr_arbiter: one instance at MIN_GAP=4 and one at
// MIN_GAP=1, with an expected-write queue per instance.
module tb_opl3_reg_wr_arbiter;
  import opl3_pkg::*;

  localparam int DEPTH   = 8;
  localparam int MIN_GAP = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A (MIN_GAP=4)
  logic       host_wr_valid, seq_wr_valid;
  logic [8:0] host_wr_addr, seq_wr_addr;
  logic [7:0] host_wr_data, seq_wr_data;
  logic       host_wr_full, seq_wr_ready, opl3_reg_wr_valid, host_overflow, busy;
  logic [8:0] opl3_reg_wr_addr;
  logic [7:0] opl3_reg_wr_data;
  arb_state_t arb_state;

  // instance B (MIN_GAP=1)
  logic       hb_valid;
  logic [8:0] hb_addr;
  logic [7:0] hb_data;
  logic       full_b, seq_ready_b, valid_b, overflow_b, busy_b;
  logic [8:0] addr_b;
  logic [7:0] data_b;
  arb_state_t state_b;

`ifdef OPL3_REG_WR_ARB_STATS_EN
  logic [15:0] host_wr_count, seq_wr_count, host_cnt_b, seq_cnt_b;
  logic [3:0]  max_fifo_level, max_lvl_b;
`endif

  opl3_reg_wr_arbiter #(.HOST_DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_full(host_wr_full),
    .seq_wr_valid(seq_wr_valid), .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
    .seq_wr_ready(seq_wr_ready),
    .opl3_reg_wr_valid(opl3_reg_wr_valid), .opl3_reg_wr_addr(opl3_reg_wr_addr),
    .opl3_reg_wr_data(opl3_reg_wr_data),
    .host_overflow(host_overflow), .busy(busy), .arb_state(arb_state)
`ifdef OPL3_REG_WR_ARB_STATS_EN
    , .host_wr_count(host_wr_count), .seq_wr_count(seq_wr_count), .max_fifo_level(max_fifo_level)
`endif
  );

  opl3_reg_wr_arbiter #(.HOST_DEPTH(DEPTH), .MIN_GAP(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(hb_valid), .host_wr_addr(hb_addr), .host_wr_data(hb_data),
    .host_wr_full(full_b),
    .seq_wr_valid(1'b0), .seq_wr_addr(9'd0), .seq_wr_data(8'd0),
    .seq_wr_ready(seq_ready_b),
    .opl3_reg_wr_valid(valid_b), .opl3_reg_wr_addr(addr_b), .opl3_reg_wr_data(data_b),
    .host_overflow(overflow_b), .busy(busy_b), .arb_state(state_b)
`ifdef OPL3_REG_WR_ARB_STATS_EN
    , .host_wr_count(host_cnt_b), .seq_wr_count(seq_cnt_b), .max_fifo_level(max_lvl_b)
`endif
  );

  // scoreboard
  logic [16:0] exp_q[$];
  logic [16:0] exp_b_q[$];
  int total = 0;
  int bad = 0;
  int pulses_a = 0;
  int last_pulse_a = -1;
  int pulses_b = 0;
  int first_pulse_b = -1;
  int last_pulse_b = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      last_pulse_a = -1;
    end else if (opl3_reg_wr_valid) begin
      pulses_a++;
      check_eq("a_pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check_eq("a_pulse_payload", 32'({opl3_reg_wr_addr, opl3_reg_wr_data}), 32'(exp_q.pop_front()));
      if (last_pulse_a >= 0)
        check_eq("a_pulse_spacing", 32'(cyc - last_pulse_a >= MIN_GAP), 32'd1);
      last_pulse_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (reset_n && valid_b) begin
      pulses_b++;
      if (first_pulse_b < 0) first_pulse_b = cyc;
      last_pulse_b = cyc;
      check_eq("b_pulse_expected", 32'(exp_b_q.size() != 0), 32'd1);
      if (exp_b_q.size() != 0)
        check_eq("b_pulse_payload", 32'({addr_b, data_b}), 32'(exp_b_q.pop_front()));
    end
  end

  // driver tasks
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic host_wr(input logic [8:0] a, input logic [7:0] d);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    sync();
    host_wr_valid = 1'b0;
  endtask

  task automatic seq_send(input logic [8:0] a, input logic [7:0] d, output int rdy_cyc);
    int n;
    n = 0;
    rdy_cyc = -1;
    seq_wr_valid = 1'b1;
    seq_wr_addr  = a;
    seq_wr_data  = d;
    while (n < 64) begin
      @(negedge clk);
      if (seq_wr_ready) begin
        rdy_cyc = cyc;
        break;
      end
      n++;
    end
    if (rdy_cyc < 0) check_eq("seq_ready_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    if (busy || exp_q.size() != 0) check_eq("idle_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sync();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r[5];
    int p0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    seq_wr_valid  = 1'b0; seq_wr_addr  = '0; seq_wr_data  = '0;
    hb_valid = 1'b0; hb_addr = '0; hb_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(opl3_reg_wr_valid), 32'd0);
    check_eq("rst_addr", 32'(opl3_reg_wr_addr), 32'd0);
    check_eq("rst_data", 32'(opl3_reg_wr_data), 32'd0);
    check_eq("rst_full", 32'(host_wr_full), 32'd0);
    check_eq("rst_overflow", 32'(host_overflow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_seq_ready", 32'(seq_wr_ready), 32'd0);
    check_eq("rst_state", 32'(arb_state), 32'(IDLE));
    reset_n = 1'b1;
    sync();

    // single host write: pulse two cycles after the strobe
    c0 = cyc;
    exp_q.push_back({9'h0B5, 8'hA5});
    host_wr(9'h0B5, 8'hA5);
    goto_neg(c0 + 1);
    check_eq("t1_no_early_pulse", 32'(opl3_reg_wr_valid), 32'd0);
    goto_neg(c0 + 2);
    check_eq("t1_pulse", 32'(opl3_reg_wr_valid), 32'd1);
    check_eq("t1_addr", 32'(opl3_reg_wr_addr), 32'h0B5);
    check_eq("t1_data", 32'(opl3_reg_wr_data), 32'hA5);
    goto_neg(c0 + 3);
    check_eq("t1_pulse_single", 32'(opl3_reg_wr_valid), 32'd0);
    check_eq("t1_addr_hold", 32'(opl3_reg_wr_addr), 32'h0B5);
    goto_neg(c0 + 4);
    check_eq("t1_busy_in_gap", 32'(busy), 32'd1);
    check_eq("t1_state_gap", 32'(arb_state), 32'(GAP));
    goto_neg(c0 + 5);
    check_eq("t1_busy_after_gap", 32'(busy), 32'd0);
    check_eq("t1_state_idle", 32'(arb_state), 32'(IDLE));
    sync();

    // sequencer alone: ready every MIN_GAP cycles
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({9'(9'h100 + i), 8'(8'h40 + i)});
      seq_send(9'(9'h100 + i), 8'(8'h40 + i), r[i]);
    end
    seq_wr_valid = 1'b0;
    for (int i = 1; i < 5; i++) check_eq("t2_ready_spacing", 32'(r[i] - r[i-1]), 32'd4);
    wait_idle(100);

    // both pending after reset: host first, then alternating
    pulse_reset();
    c0 = cyc;
    exp_q.push_back({9'h020, 8'h11});
    exp_q.push_back({9'h120, 8'h21});
    exp_q.push_back({9'h021, 8'h12});
    exp_q.push_back({9'h121, 8'h22});
    exp_q.push_back({9'h022, 8'h13});
    exp_q.push_back({9'h122, 8'h23});
    fork
      begin
        for (int i = 0; i < 3; i++) host_wr(9'(9'h020 + i), 8'(8'h11 + i));
      end
      begin
        sync();
        for (int i = 0; i < 3; i++) seq_send(9'(9'h120 + i), 8'(8'h21 + i), r[i]);
        seq_wr_valid = 1'b0;
      end
    join
    check_eq("t3_first_seq_grant", 32'(r[0] - c0), 32'd5);
    check_eq("t3_seq_alternate_1", 32'(r[1] - r[0]), 32'd8);
    check_eq("t3_seq_alternate_2", 32'(r[2] - r[1]), 32'd8);
    wait_idle(100);

    // 14-write burst into depth 8 at MIN_GAP=4: writes 12 and 13 dropped
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          if (i != 11 && i != 12) exp_q.push_back({9'(9'h040 + i), 8'(8'h80 + i)});
          host_wr(9'(9'h040 + i), 8'(8'h80 + i));
        end
      end
      begin
        goto_neg(c0 + 10);
        check_eq("t4_not_full_c10", 32'(host_wr_full), 32'd0);
        check_eq("t4_no_overflow_c10", 32'(host_overflow), 32'd0);
        goto_neg(c0 + 11);
        check_eq("t4_full_c11", 32'(host_wr_full), 32'd1);
        check_eq("t4_no_overflow_c11", 32'(host_overflow), 32'd0);
        goto_neg(c0 + 12);
        check_eq("t4_overflow_c12", 32'(host_overflow), 32'd1);
        goto_neg(c0 + 14);
        check_eq("t4_full_after_pop_push", 32'(host_wr_full), 32'd1);
      end
    join
    wait_idle(200);
    check_eq("t4_overflow_sticky", 32'(host_overflow), 32'd1);
    check_eq("t4_not_full_drained", 32'(host_wr_full), 32'd0);

    // reset during activity: pulse cancelled, FIFO flushed
    c0 = cyc;
    exp_q.push_back({9'h060, 8'hC0});
    fork
      begin
        for (int i = 0; i < 4; i++) host_wr(9'(9'h060 + i), 8'(8'hC0 + i));
      end
      begin
        goto_neg(c0 + 2);
        check_eq("t5_pulse_before_reset", 32'(opl3_reg_wr_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_valid_cleared", 32'(opl3_reg_wr_valid), 32'd0);
        check_eq("t5_addr_cleared", 32'(opl3_reg_wr_addr), 32'd0);
        check_eq("t5_data_cleared", 32'(opl3_reg_wr_data), 32'd0);
        check_eq("t5_overflow_cleared", 32'(host_overflow), 32'd0);
        check_eq("t5_busy_cleared", 32'(busy), 32'd0);
        check_eq("t5_state_idle", 32'(arb_state), 32'(IDLE));
      end
    join
    @(negedge clk);
    reset_n = 1'b1;
    p0 = pulses_a;
    repeat (10) @(negedge clk);
    check_eq("t5_no_pulses_after_reset", 32'(pulses_a - p0), 32'd0);
    check_eq("t5_fifo_empty_busy", 32'(busy), 32'd0);
    check_eq("t5_exp_drained", 32'(exp_q.size()), 32'd0);
    sync();

    // MIN_GAP=1 instance: same burst, back-to-back issue, nothing dropped
    for (int i = 0; i < 14; i++) begin
      exp_b_q.push_back({9'(9'h080 + i), 8'(8'h30 + i)});
      hb_valid = 1'b1;
      hb_addr  = 9'(9'h080 + i);
      hb_data  = 8'(8'h30 + i);
      sync();
    end
    hb_valid = 1'b0;
    for (int n = 0; n < 100 && exp_b_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check_eq("t6_b_all_issued", 32'(pulses_b), 32'd14);
    check_eq("t6_b_back_to_back", 32'(last_pulse_b - first_pulse_b), 32'd13);
    check_eq("t6_b_no_overflow", 32'(overflow_b), 32'd0);
    check_eq("t6_b_not_full", 32'(full_b), 32'd0);
    check_eq("t6_b_idle", 32'(busy_b), 32'd0);
    check_eq("t6_b_state", 32'(state_b), 32'(IDLE));
    check_eq("t6_b_seq_ready", 32'(seq_ready_b), 32'd0);
    sync();

`ifdef OPL3_REG_WR_ARB_STATS_EN
    // counters: 3 host + 2 seq writes, peak FIFO level 2
    pulse_reset();
    check_eq("t7_host_count_reset", 32'(host_wr_count), 32'd0);
    exp_q.push_back({9'h0A0, 8'h01});
    exp_q.push_back({9'h1A0, 8'h11});
    exp_q.push_back({9'h0A1, 8'h02});
    exp_q.push_back({9'h1A1, 8'h12});
    exp_q.push_back({9'h0A2, 8'h03});
    for (int i = 0; i < 3; i++) host_wr(9'(9'h0A0 + i), 8'(8'h01 + i));
    for (int i = 0; i < 2; i++) seq_send(9'(9'h1A0 + i), 8'(8'h11 + i), r[i]);
    seq_wr_valid = 1'b0;
    wait_idle(100);
    check_eq("t7_host_count", 32'(host_wr_count), 32'd3);
    check_eq("t7_seq_count", 32'(seq_wr_count), 32'd2);
    check_eq("t7_max_level", 32'(max_fifo_level), 32'd2);
    check_eq("t7_b_counts", 32'({host_cnt_b, seq_cnt_b}), 32'd0);
    check_eq("t7_b_max_level", 32'(max_lvl_b), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
